// File: rtl/img_dma_if.sv
// img_dma_if
//   Bundles every handshake and bus signal of the image DMA engine so the
//   controller and its environment connect through a single port.
//   Groups:
//     register bus : reg_wr_en, reg_sel[1:0], reg_data[27:0], start
//     status       : busy, done
//     page read    : rd_req_valid/rd_req_ready/rd_addr, rd_data_valid/rd_data
//     page output  : pg_valid/pg_ready/pg_data
//     result in    : res_valid/res_ready/res_data
//     result write : wr_req_valid/wr_req_ready/wr_addr/wr_data
//   Modports:
//     master : the DMA controller
//     slave  : firmware, memory, consumer and classifier side
interface img_dma_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  parameter int RES_W  = 64
);
  logic              reg_wr_en;
  logic [1:0]        reg_sel;
  logic [27:0]       reg_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              pg_valid;
  logic              pg_ready;
  logic [DATA_W-1:0] pg_data;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic              res_ready;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  reg_wr_en, reg_sel, reg_data, start,
    input  rd_req_ready, rd_data_valid, rd_data,
    input  pg_ready, res_valid, res_data, wr_req_ready,
    output busy, done, rd_req_valid, rd_addr,
    output pg_valid, pg_data, res_ready,
    output wr_req_valid, wr_addr, wr_data
  );

  modport slave (
    output reg_wr_en, reg_sel, reg_data, start,
    output rd_req_ready, rd_data_valid, rd_data,
    output pg_ready, res_valid, res_data, wr_req_ready,
    input  busy, done, rd_req_valid, rd_addr,
    input  pg_valid, pg_data, res_ready,
    input  wr_req_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/img_dma_ctrl.sv
// img_dma_ctrl
//   Image fetch and result writeback engine. Firmware programs the image
//   address, image count and result address, then pulses start. For each
//   image the engine issues PAGES_PER_IMG page reads (several in flight,
//   throttled so reads in flight plus buffered pages never exceed MAX_OUT),
//   streams the returned pages to the consumer through a small FIFO, waits
//   for one classifier result and writes it to the result address.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset, aborts any operation
//     bus  : img_dma_if.master (register bus, start, busy/done, page read,
//            page output, result input, result write)
module img_dma_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 512,
  parameter int RES_W         = 64,
  parameter int PAGES_PER_IMG = 1407,
  parameter int MAX_OUT       = 4,
  parameter int CNT_W         = 16
) (
  input  logic      clk,
  input  logic      rst,
  img_dma_if.master bus
);
  localparam int IW = $clog2(PAGES_PER_IMG + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(MAX_OUT);
  localparam logic [IW-1:0] PAGES   = IW'(PAGES_PER_IMG);
  localparam logic [OW:0]   MAX_OCC = (OW + 1)'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_RES, WRITE_RES} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] img_addr_reg;
  logic [ADDR_W-1:0] rslt_addr_reg;
  logic [CNT_W-1:0]  img_cnt_reg;
  logic [IW-1:0]     issued_reg;
  logic [OW-1:0]     inflight_reg;
  logic [OW-1:0]     buffered_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [RES_W-1:0]  result_reg;
  logic              done_reg;
  logic [DATA_W-1:0] fifo_mem [MAX_OUT];

  logic             cfg_wr;
  logic             wr_img_addr;
  logic             wr_img_cnt;
  logic             wr_rslt_addr;
  logic [CNT_W-1:0] cnt_eff;
  logic             start_ok;
  logic [OW:0]      occ;
  logic             fetch_req;
  logic             res_take;
  logic             wr_req;
  logic             rd_fire;
  logic             push;
  logic             pop;
  logic             wr_fire;
  logic             last_img;

  // Register writes only land while idle.
  assign cfg_wr       = bus.reg_wr_en && (state_reg == IDLE);
  assign wr_img_addr  = cfg_wr && (bus.reg_sel == 2'b00);
  assign wr_img_cnt   = cfg_wr && (bus.reg_sel == 2'b01);
  assign wr_rslt_addr = cfg_wr && (bus.reg_sel == 2'b10);

  // A count written in the same cycle as start is the one start acts on.
  assign cnt_eff  = wr_img_cnt ? CNT_W'(bus.reg_data) : img_cnt_reg;
  assign start_ok = bus.start && (state_reg == IDLE);

  assign occ      = {1'b0, inflight_reg} + {1'b0, buffered_reg};
  assign rd_fire  = fetch_req && bus.rd_req_ready;
  // Returns are only accepted against an outstanding read, so data from
  // reads issued before a reset never reaches the FIFO.
  assign push     = bus.rd_data_valid && (state_reg == FETCH) && (inflight_reg != '0);
  assign pop      = (buffered_reg != '0) && bus.pg_ready;
  assign wr_fire  = wr_req && bus.wr_req_ready;
  assign last_img = (img_cnt_reg == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fetch_req  = 1'b0;
    res_take   = 1'b0;
    wr_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && (cnt_eff != '0)) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        fetch_req = (issued_reg < PAGES) && (occ < MAX_OCC);
        // Leave only once every page of this image has reached the consumer.
        if ((issued_reg == PAGES) && (inflight_reg == '0) && (buffered_reg == '0)) begin
          state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        res_take = 1'b1;
        if (bus.res_valid) begin
          state_next = WRITE_RES;
        end
      end
      WRITE_RES: begin
        wr_req = 1'b1;
        if (bus.wr_req_ready) begin
          state_next = last_img ? IDLE : FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_addr_reg  <= '0;
      rslt_addr_reg <= '0;
      img_cnt_reg   <= '0;
      issued_reg    <= '0;
      inflight_reg  <= '0;
      buffered_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      result_reg    <= '0;
      done_reg      <= 1'b0;
    end else begin
      if (wr_img_addr) begin
        img_addr_reg <= ADDR_W'(bus.reg_data);
      end else if (rd_fire) begin
        img_addr_reg <= img_addr_reg + ADDR_W'(1);
      end

      if (wr_rslt_addr) begin
        rslt_addr_reg <= ADDR_W'(bus.reg_data);
      end else if (wr_fire) begin
        rslt_addr_reg <= rslt_addr_reg + ADDR_W'(1);
      end

      if (wr_img_cnt) begin
        img_cnt_reg <= CNT_W'(bus.reg_data);
      end else if (wr_fire) begin
        img_cnt_reg <= img_cnt_reg - CNT_W'(1);
      end

      if (rd_fire) begin
        issued_reg <= issued_reg + IW'(1);
      end else if (wr_fire) begin
        issued_reg <= '0;
      end

      case ({rd_fire, push})
        2'b10:   inflight_reg <= inflight_reg + OW'(1);
        2'b01:   inflight_reg <= inflight_reg - OW'(1);
        default: inflight_reg <= inflight_reg;
      endcase

      case ({push, pop})
        2'b10:   buffered_reg <= buffered_reg + OW'(1);
        2'b01:   buffered_reg <= buffered_reg - OW'(1);
        default: buffered_reg <= buffered_reg;
      endcase

      // MAX_OUT is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end

      if ((state_reg == WAIT_RES) && bus.res_valid) begin
        result_reg <= bus.res_data;
      end

      // Zero-image start completes immediately with a pulse next cycle.
      done_reg <= start_ok && (cnt_eff == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (rst) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          fifo_mem[gi] <= bus.rd_data;
        end
      end
    end
  endgenerate

  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = done_reg || (wr_fire && last_img);
  assign bus.rd_req_valid = fetch_req;
  assign bus.rd_addr      = img_addr_reg;
  assign bus.pg_valid     = (buffered_reg != '0);
  // Head entry shown combinationally so a fresh page is visible at once.
  assign bus.pg_data      = (buffered_reg != '0) ? fifo_mem[rd_ptr_reg] : '0;
  assign bus.res_ready    = res_take;
  assign bus.wr_req_valid = wr_req;
  assign bus.wr_addr      = rslt_addr_reg;
  assign bus.wr_data      = DATA_W'(result_reg);
endmodule

// File: tb/tb_img_dma_ctrl.sv
// tb_img_dma_ctrl
//   Directed bench for img_dma_ctrl with 4 pages per image and at most 2
//   outstanding pages. A memory model answers reads after 3 cycles with a
//   page pattern derived from the address; the classifier source offers
//   results 0xC000, 0xC001, ... in order.
`timescale 1ns/1ps
module tb_img_dma_ctrl;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int RES_W   = 16;
  localparam int PAGES   = 4;
  localparam int MAX_OUT = 2;
  localparam int CNT_W   = 8;
  localparam int LAT     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  img_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  img_dma_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W),
    .PAGES_PER_IMG(PAGES), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] page_of(input logic [ADDR_W-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  // Transaction logs and environment state, all owned by the negedge process.
  logic [ADDR_W-1:0] rd_log[$];
  logic [DATA_W-1:0] pg_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  int                wr_pg_log[$];
  int   done_cnt        = 0;
  int   busy_after_done = 0;
  int   over_cnt        = 0;
  int   peak            = 0;
  int   outstanding     = 0;
  int   res_idx         = 0;
  logic done_seen       = 1'b0;
  logic res_hs_prev     = 1'b0;
  logic [LAT-1:0]    pipe_v = '0;
  logic [ADDR_W-1:0] pipe_a [LAT];

  always @(negedge clk) begin
    logic fire;
    logic pop;
    fire = bus.rd_req_valid && bus.rd_req_ready;
    pop  = bus.pg_valid && bus.pg_ready;
    if (fire) rd_log.push_back(bus.rd_addr);
    if (pop) begin
      pg_log.push_back(bus.pg_data);
      $display("page   #%0d data=0x%h", pg_log.size() - 1, bus.pg_data);
    end
    if (bus.wr_req_valid && bus.wr_req_ready) begin
      wr_addr_log.push_back(bus.wr_addr);
      wr_data_log.push_back(bus.wr_data);
      wr_pg_log.push_back(pg_log.size());
      $display("result write addr=0x%h data=0x%h", bus.wr_addr, bus.wr_data);
    end
    if (done_seen && bus.busy) busy_after_done++;
    done_seen = bus.done;
    if (bus.done) done_cnt++;
    outstanding = outstanding + (fire ? 1 : 0) - (pop ? 1 : 0);
    if (rst) outstanding = 0;
    if (outstanding > peak) peak = outstanding;
    if (outstanding > MAX_OUT) over_cnt++;
    // classifier source: next value offered one cycle after each handshake
    if (res_hs_prev) res_idx++;
    res_hs_prev  = bus.res_valid && bus.res_ready;
    bus.res_data = RES_W'(32'hC000 + res_idx);
    // memory: fixed latency, in-order returns
    bus.rd_data_valid = pipe_v[LAT-1];
    bus.rd_data       = pipe_v[LAT-1] ? page_of(pipe_a[LAT-1]) : '0;
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = fire;
    pipe_a[0] = bus.rd_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [27:0] data);
    bus.reg_wr_en = 1'b1;
    bus.reg_sel   = sel;
    bus.reg_data  = data;
    tick();
    bus.reg_wr_en = 1'b0;
  endtask

  task automatic program_regs(input logic [27:0] a, input logic [27:0] n, input logic [27:0] r);
    write_reg(2'b00, a);
    write_reg(2'b01, n);
    write_reg(2'b10, r);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int prev;
    int n;
    prev = done_cnt;
    n    = 0;
    while (done_cnt == prev && n < budget) begin
      tick();
      n++;
    end
    check_value({tag, "_done_seen"}, 64'(done_cnt > prev), 64'd1);
    repeat (3) tick();
  endtask

  task automatic check_reads(input string tag, input int base, input logic [ADDR_W-1:0] first, input int n);
    check_value({tag, "_rd_count"}, 64'(rd_log.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < rd_log.size())
        check_value($sformatf("%s_rd%0d", tag, i), 64'(rd_log[base+i]), 64'(first + ADDR_W'(i)));
    end
  endtask

  task automatic check_pages(input string tag, input int base, input logic [ADDR_W-1:0] first, input int n);
    check_value({tag, "_pg_count"}, 64'(pg_log.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < pg_log.size())
        check_value($sformatf("%s_pg%0d", tag, i), 64'(pg_log[base+i]), 64'(page_of(first + ADDR_W'(i))));
    end
  endtask

  task automatic check_writes(input string tag, input int wbase, input logic [ADDR_W-1:0] first,
                              input int n, input int rbase, input int pbase);
    logic [RES_W-1:0] r;
    check_value({tag, "_wr_count"}, 64'(wr_addr_log.size() - wbase), 64'(n));
    for (int j = 0; j < n; j++) begin
      if (wbase + j < wr_addr_log.size()) begin
        r = RES_W'(32'hC000 + rbase + j);
        check_value($sformatf("%s_wr%0d_addr", tag, j), 64'(wr_addr_log[wbase+j]), 64'(first + ADDR_W'(j)));
        check_value($sformatf("%s_wr%0d_data", tag, j), 64'(wr_data_log[wbase+j]), 64'(r));
        check_value($sformatf("%s_wr%0d_after_pages", tag, j), 64'(wr_pg_log[wbase+j]),
                    64'(pbase + PAGES * (j + 1)));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_ctrl"}, 64'({bus.busy, bus.done, bus.rd_req_valid, bus.pg_valid,
                                     bus.res_ready, bus.wr_req_valid}), 64'd0);
    check_value({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    check_value({tag, "_pg_data"}, 64'(bus.pg_data), 64'd0);
    check_value({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    check_value({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rb, pb, wb, resb, db;
    bus.reg_wr_en    = 1'b0;
    bus.reg_sel      = 2'b00;
    bus.reg_data     = '0;
    bus.start        = 1'b0;
    bus.rd_req_ready = 1'b1;
    bus.pg_ready     = 1'b1;
    bus.res_valid    = 1'b1;
    bus.wr_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    tick();

    // one image
    rb = rd_log.size(); pb = pg_log.size(); wb = wr_addr_log.size(); resb = res_idx; db = done_cnt;
    program_regs(28'h100, 28'd1, 28'h800);
    bus.start = 1'b1;
    @(negedge clk);
    check_value("t1_rdreq_at_start", 64'(bus.rd_req_valid), 64'd0);
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check_value("t1_rdreq_after_start", 64'(bus.rd_req_valid), 64'd1);
    run_to_done("t1", 200);
    check_reads("t1", rb, 32'h100, 4);
    check_pages("t1", pb, 32'h100, 4);
    check_writes("t1", wb, 32'h800, 1, resb, pb);
    check_value("t1_done_pulses", 64'(done_cnt - db), 64'd1);
    check_value("t1_peak_outstanding", 64'(peak), 64'(MAX_OUT));

    // three images back to back
    rb = rd_log.size(); pb = pg_log.size(); wb = wr_addr_log.size(); resb = res_idx; db = done_cnt;
    program_regs(28'h100, 28'd3, 28'h800);
    pulse_start();
    run_to_done("t2", 500);
    check_reads("t2", rb, 32'h100, 12);
    check_pages("t2", pb, 32'h100, 12);
    check_writes("t2", wb, 32'h800, 3, resb, pb);
    check_value("t2_done_pulses", 64'(done_cnt - db), 64'd1);

    // consumer stall mid-image
    rb = rd_log.size(); pb = pg_log.size(); wb = wr_addr_log.size(); resb = res_idx; db = done_cnt;
    program_regs(28'h200, 28'd1, 28'h900);
    pulse_start();
    repeat (4) tick();
    bus.pg_ready = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check_value("t3_stall_rdreq", 64'(bus.rd_req_valid), 64'd0);
    check_value("t3_stall_pgvalid", 64'(bus.pg_valid), 64'd1);
    check_value("t3_stall_outstanding", 64'(outstanding), 64'(MAX_OUT));
    tick();
    bus.pg_ready = 1'b1;
    run_to_done("t3", 300);
    check_reads("t3", rb, 32'h200, 4);
    check_pages("t3", pb, 32'h200, 4);
    check_writes("t3", wb, 32'h900, 1, resb, pb);
    check_value("t3_over_limit", 64'(over_cnt), 64'd0);

    // zero images
    rb = rd_log.size(); db = done_cnt;
    write_reg(2'b01, 28'd0);
    bus.start = 1'b1;
    @(negedge clk);
    check_value("t4_done_at_start", 64'(bus.done), 64'd0);
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check_value("t4_done_next", 64'(bus.done), 64'd1);
    check_value("t4_busy_next", 64'(bus.busy), 64'd0);
    tick();
    @(negedge clk);
    check_value("t4_done_after", 64'(bus.done), 64'd0);
    check_value("t4_no_reads", 64'(rd_log.size() - rb), 64'd0);
    check_value("t4_done_pulses", 64'(done_cnt - db), 64'd1);
    tick();

    // count write with start, then writes and start while busy
    rb = rd_log.size(); pb = pg_log.size(); wb = wr_addr_log.size(); resb = res_idx; db = done_cnt;
    write_reg(2'b00, 28'h300);
    write_reg(2'b10, 28'hA00);
    bus.reg_wr_en = 1'b1;
    bus.reg_sel   = 2'b01;
    bus.reg_data  = 28'd1;
    bus.start     = 1'b1;
    tick();
    bus.reg_wr_en = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    check_value("t5_busy_after_start", 64'(bus.busy), 64'd1);
    check_value("t5_no_early_done", 64'(done_cnt - db), 64'd0);
    tick();
    write_reg(2'b00, 28'h5000);
    pulse_start();
    write_reg(2'b01, 28'd5);
    run_to_done("t5", 300);
    check_reads("t5", rb, 32'h300, 4);
    check_writes("t5", wb, 32'hA00, 1, resb, pb);
    check_value("t5_done_pulses", 64'(done_cnt - db), 64'd1);

    // reset with two reads in flight
    rb = rd_log.size(); pb = pg_log.size(); db = done_cnt;
    program_regs(28'h400, 28'd1, 28'hB00);
    pulse_start();
    tick();
    tick();
    check_value("t6_inflight_before_rst", 64'(rd_log.size() - rb), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_after_rst");
    repeat (8) tick();
    check_value("t6_no_late_pages", 64'(pg_log.size() - pb), 64'd0);
    check_value("t6_no_done_on_abort", 64'(done_cnt - db), 64'd0);
    rb = rd_log.size(); pb = pg_log.size(); wb = wr_addr_log.size(); resb = res_idx; db = done_cnt;
    program_regs(28'h600, 28'd2, 28'hC00);
    pulse_start();
    run_to_done("t6", 400);
    check_reads("t6", rb, 32'h600, 8);
    check_pages("t6", pb, 32'h600, 8);
    check_writes("t6", wb, 32'hC00, 2, resb, pb);
    check_value("t6_done_pulses", 64'(done_cnt - db), 64'd1);

    check_value("busy_low_after_done", 64'(busy_after_done), 64'd0);
    check_value("never_over_limit", 64'(over_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/img_dma_ctrl.md
Name: img_dma_ctrl

Overview:
Parametrised image-fetch and result-writeback engine for the detection pipeline. It replaces the fixed single-outstanding image page loop with a multi-outstanding, credit-throttled reader. Firmware programs image address, image count and result address through the decode register bus, then issues start. The block streams each image's pages to the downstream consumer (IPGU/out FIFO), collects one classifier result per image, and writes that result to memory before moving to the next image.

Parameters:
ADDR_W, 32, memory address width in page units
DATA_W, 512, page data width
RES_W, 64, classifier result width (RES_W <= DATA_W)
PAGES_PER_IMG, 1407, pages fetched per image
MAX_OUT, 4, maximum of (reads in flight + pages buffered); power of two, 2..16
CNT_W, 16, image counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
reg_wr_en  in  1  register write strobe
reg_sel  in  2  00 img_addr, 01 img_cnt, 10 rslt_addr, 11 reserved (write ignored)
reg_data  in  28  register write data, zero-extended or truncated to the target width
start  in  1  begin processing; 1-cycle pulse
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse when the last result write is accepted
rd_req_valid  out  1  page read request
rd_req_ready  in  1  memory accepts the read
rd_addr  out  ADDR_W  read page address
rd_data_valid  in  1  returned page; returns arrive in request order
rd_data  in  DATA_W  returned page data
pg_valid  out  1  page to consumer
pg_ready  in  1  consumer accepts the page
pg_data  out  DATA_W  page data
res_valid  in  1  classifier result valid
res_data  in  RES_W  result
res_ready  out  1  result consumed
wr_req_valid  out  1  result write request
wr_req_ready  in  1  memory accepts the write
wr_addr  out  ADDR_W  result address
wr_data  out  DATA_W  result zero-extended in the LSBs

Behaviour:
- Reset: state IDLE. All outputs 0. Registers, counters and the buffer are cleared. Reset during any operation aborts it immediately, and an rd_data_valid arriving after reset is ignored. There is no done pulse on abort.
- Registers: a write takes effect the next cycle, only in IDLE. Writes while busy are ignored. start while busy is ignored. reg_wr_en and start in the same IDLE cycle: the write is applied first, and start uses the new value.
- States:
  - IDLE -> FETCH on start if img_cnt != 0. If img_cnt == 0, done pulses the next cycle and the state stays IDLE.
  - FETCH: rd_req_valid = (issued < PAGES_PER_IMG) && (inflight + buffered < MAX_OUT). rd_addr = img_addr. A request fires on valid && ready. On each fire: img_addr += 1 (wraps mod 2^ADDR_W), issued += 1, inflight += 1. rd_req_valid asserts the cycle after start.
  - Page return: rd_data_valid writes a MAX_OUT-deep FIFO; inflight -= 1, buffered += 1. pg_valid = FIFO non-empty, and pg_data shows the head with no bubble. A pg handshake pops the FIFO. A simultaneous push and pop keeps the count unchanged. Overflow cannot occur by construction; the verifier asserts this.
  - FETCH -> WAIT_RES when issued == PAGES_PER_IMG, inflight == 0 and the FIFO is empty (all pages delivered).
  - WAIT_RES: res_ready = 1. On res_valid, capture res_data, then go to WRITE_RES. res_ready is 0 in all other states.
  - WRITE_RES: wr_req_valid = 1, wr_addr = rslt_addr. Hold until wr_req_ready. On accept: rslt_addr += 1, img_cnt -= 1, issued = 0. If the new img_cnt == 0, done pulses and the state goes to IDLE; otherwise FETCH.
- img_addr continues contiguously across images, so image n starts at base + n*PAGES_PER_IMG.
- After done, registers read back as their final incremented values. Firmware reprograms them before the next start.
- Counter widths: issued is clog2(PAGES_PER_IMG+1) bits. inflight and buffered are clog2(MAX_OUT+1) bits.

Test Plan:
- PAGES_PER_IMG=4, MAX_OUT=2, img_addr=0x100, img_cnt=1, rslt_addr=0x800, memory always ready with 3-cycle latency, pg_ready=1.
  -> Read addresses 0x100..0x103 in order, never more than 2 in flight. 4 pages are delivered in order. One write of the result to 0x800. done pulses once. busy is low the next cycle.
- Same setup with img_cnt=3.
  -> Reads cover 0x100..0x10B. Writes go to 0x800, 0x801, 0x802, each after its image's last page. A single done pulse follows the third write.
- pg_ready held low for 20 cycles mid-image.
  -> At most MAX_OUT pages are outstanding or buffered. rd_req_valid drops. No page is lost or duplicated after pg_ready rises.
- img_cnt=0, then start.
  -> No reads, done pulses the cycle after start.
- Register write and second start during FETCH.
  -> Both are ignored, and the address sequence is unchanged.
- rst asserted mid-FETCH with 2 reads in flight.
  -> All outputs are 0 the next cycle and the late rd_data_valid causes no pg_valid. A fresh program and start then runs correctly from the new img_addr.
